ctr_buffer_ctrl: RTL and testbench
==================================

// Module: ctr_buffer_ctrl
// PURPOSE
//  Controller and storage for the Control Transfer Records (CTR) ring buffer.
//  Takes the serialized source/target/type records produced by the CTR emitter.
//  Filters them by privilege and type, and writes them into a DEPTH-entry circular buffer.
//  Serves indexed CSR reads/writes (sireg* path) and sequences sctrclr clears and freeze.
// PARAMETERS
//  DEPTH   16  entries in ring; power of 2, 16..256
//  XLEN    64  width of source/target words
//  TYPE_W  4   CTR type encoding width (0 = NONE)
// PORTS
//  clk_i           in   1                  clock
//  rst_i           in   1                  async reset, active-high
//  rec_valid_i     in   1                  record strobe from CTR emitter
//  rec_source_i    in   XLEN               {pc[XLEN-1:1], v}
//  rec_target_i    in   XLEN               {pc[XLEN-1:1], misp}
//  rec_type_i      in   TYPE_W             transfer type
//  rec_priv_i      in   2                  privilege of source instr (U=0,S=1,M=3)
//  priv_en_i       in   3                  record enable [0]=U [1]=S [2]=M
//  type_inh_i      in   2**TYPE_W          per-type inhibit mask
//  freeze_i        in   1                  set frozen (trap with freeze enabled)
//  unfreeze_i      in   1                  clear frozen (sctrstatus write)
//  clear_i         in   1                  sctrclr request
//  csr_req_i       in   1                  CSR access strobe
//  csr_we_i        in   1                  1 = write
//  csr_idx_i       in   8                  logical index, 0 = newest
//  csr_sel_i       in   2                  0 source, 1 target, 2 data, 3 reserved
//  csr_wdata_i     in   XLEN               write data
//  csr_rvalid_o    out  1                  read/write response, 1 cycle after req
//  csr_rdata_o     out  XLEN               read data (0 for writes)
//  wrptr_o         out  $clog2(DEPTH)      next physical slot to write
//  frozen_o        out  1                  recording frozen
//  busy_o          out  1                  clear in progress
// BEHAVIOUR
//  Reset: all entries, wrptr_o, frozen_o, busy_o, csr_rvalid_o, csr_rdata_o = 0. FSM = RUN.
//  FSM: RUN --clear_i--> CLEAR. CLEAR lasts exactly DEPTH cycles.
//   - Each CLEAR cycle zeroes entry clr_cnt (0..DEPTH-1).
//   - On the last CLEAR cycle wrptr<=0, then back to RUN.
//   - busy_o=1 throughout CLEAR. clear_i during CLEAR is ignored.
//  Accept = rec_valid_i & RUN & !frozen & priv_en_i[map(rec_priv_i)]
//           & !type_inh_i[rec_type_i] & rec_type_i!=0.
//   - rec_priv_i==2 is never accepted.
//  On accept: slot[wrptr] <= {source, target, zero-extended type}. wrptr <= wrptr+1 mod DEPTH.
//   - Wrap silently overwrites the oldest entry.
//  Frozen flag: set by freeze_i, cleared by unfreeze_i; freeze_i wins if both.
//   - A record in the same cycle as freeze_i is still accepted; frozen applies from the next cycle.
//   - The frozen flag is unaffected by CLEAR.
//  CSR addressing: phys = (wrptr - 1 - csr_idx_i) mod DEPTH, using wrptr before this cycle's update.
//   - csr_idx_i >= DEPTH or csr_sel_i==3: read returns 0, write ignored.
//  CSR read: csr_rdata_o is registered; csr_rvalid_o pulses 1 cycle after csr_req_i.
//  CSR write: updates the selected field of phys; response pulse with rdata=0.
//  CSR write and accepted record on the same slot in the same cycle: CSR write wins.
//   - Only possible at idx=DEPTH-1. wrptr still advances.
//  CSR during CLEAR: reads return 0, writes dropped, rvalid still pulses.
//  Back-to-back csr_req_i is allowed, one response per request, in order.
//  Reset asserted mid-CLEAR: immediate return to reset state; no partial clear retained.
// TESTING
//  1. Reset, 3 accepted records (S-mode, type 4) -> wrptr_o=3; idx0 sel0 reads 3rd source 1 cycle later.
//  2. DEPTH+2 records -> wrptr_o=2; idx DEPTH-1 returns the 3rd record pushed; no stall.
//  3. priv_en_i=3'b010, records at U and M, type_inh_i[4]=1 with S type 4 -> none stored, wrptr_o unchanged.
//  4. freeze_i with record same cycle -> record stored; next record dropped; unfreeze_i -> recording resumes.
//  5. clear_i with 5 entries -> busy_o high DEPTH cycles; CSR read mid-clear = 0; afterwards all reads 0, wrptr_o=0.
//  6. CSR write idx DEPTH-1 sel1 = 0xDEAD with coincident record -> slot holds CSR target 0xDEAD, wrptr advances.

Source files
------------

// File: rtl/ctr_buffer_ctrl.sv
// Control Transfer Records ring buffer: filters emitter records, stores them in a
// DEPTH-entry circular buffer, serves indexed CSR access and sequences sctrclr clears.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_RUN   | normal recording, CSR access live
// ST_CLEAR | zeroing one entry per cycle for DEPTH cycles, then wrptr <= 0
module ctr_buffer_ctrl #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned XLEN   = 64,
  parameter int unsigned TYPE_W = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       rec_valid_i,
  input  logic [XLEN-1:0]            rec_source_i,
  input  logic [XLEN-1:0]            rec_target_i,
  input  logic [TYPE_W-1:0]          rec_type_i,
  input  logic [1:0]                 rec_priv_i,
  input  logic [2:0]                 priv_en_i,
  input  logic [(2**TYPE_W)-1:0]     type_inh_i,
  input  logic                       freeze_i,
  input  logic                       unfreeze_i,
  input  logic                       clear_i,
  input  logic                       csr_req_i,
  input  logic                       csr_we_i,
  input  logic [7:0]                 csr_idx_i,
  input  logic [1:0]                 csr_sel_i,
  input  logic [XLEN-1:0]            csr_wdata_i,
  output logic                       csr_rvalid_o,
  output logic [XLEN-1:0]            csr_rdata_o,
  output logic [$clog2(DEPTH)-1:0]   wrptr_o,
  output logic                       frozen_o,
  output logic                       busy_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [8:0]  DEPTH_W = 9'(DEPTH);
  localparam logic [PW-1:0] LAST_SLOT = PW'(DEPTH - 1);

  typedef enum logic {ST_RUN, ST_CLEAR} state_e;

  state_e            state_q, state_d;
  logic [PW-1:0]     wrptr_q;
  logic [PW-1:0]     clr_cnt_q;
  logic              frozen_q;
  logic              csr_rvalid_q;
  logic [XLEN-1:0]   csr_rdata_q;

  logic [XLEN-1:0]   src_q [DEPTH];
  logic [XLEN-1:0]   tgt_q [DEPTH];
  logic [TYPE_W-1:0] typ_q [DEPTH];

  logic              running;
  logic              clr_last;
  logic              priv_ok;
  logic              accept;
  logic              csr_hit;
  logic              csr_valid;
  logic [PW-1:0]     csr_phys;
  logic [XLEN-1:0]   rd_val;

  assign running  = (state_q == ST_RUN);
  assign clr_last = (clr_cnt_q == LAST_SLOT);

  // Privilege 2 (reserved) has no enable bit and is never recorded.
  always_comb begin
    priv_ok = 1'b0;
    case (rec_priv_i)
      2'd0:    priv_ok = priv_en_i[0];
      2'd1:    priv_ok = priv_en_i[1];
      2'd3:    priv_ok = priv_en_i[2];
      default: priv_ok = 1'b0;
    endcase
  end

  assign accept = rec_valid_i & running & ~frozen_q & priv_ok
                & ~type_inh_i[rec_type_i] & (rec_type_i != '0);

  assign csr_hit   = ({1'b0, csr_idx_i} < DEPTH_W) && (csr_sel_i != 2'd3);
  assign csr_valid = csr_req_i & csr_hit & running;
  assign csr_phys  = wrptr_q - PW'(1) - csr_idx_i[PW-1:0];

  always_comb begin
    rd_val = '0;
    if (csr_valid && !csr_we_i) begin
      case (csr_sel_i)
        2'd0:    rd_val = src_q[csr_phys];
        2'd1:    rd_val = tgt_q[csr_phys];
        2'd2:    rd_val = XLEN'(typ_q[csr_phys]);
        default: rd_val = '0;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (clear_i)  state_d = ST_CLEAR;
      ST_CLEAR: if (clr_last) state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_RUN;
      clr_cnt_q    <= '0;
      wrptr_q      <= '0;
      frozen_q     <= 1'b0;
      csr_rvalid_q <= 1'b0;
      csr_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      clr_cnt_q    <= (state_q == ST_CLEAR) ? clr_cnt_q + PW'(1) : '0;
      csr_rvalid_q <= csr_req_i;
      csr_rdata_q  <= rd_val;
      if (state_q == ST_CLEAR && clr_last) wrptr_q <= '0;
      else if (accept)                     wrptr_q <= wrptr_q + PW'(1);
      if (freeze_i)        frozen_q <= 1'b1;
      else if (unfreeze_i) frozen_q <= 1'b0;
    end
  end

  // CSR write is ordered after the record write so it wins on a shared slot.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        src_q[i] <= '0;
        tgt_q[i] <= '0;
        typ_q[i] <= '0;
      end
    end else begin
      if (state_q == ST_CLEAR) begin
        src_q[clr_cnt_q] <= '0;
        tgt_q[clr_cnt_q] <= '0;
        typ_q[clr_cnt_q] <= '0;
      end
      if (accept) begin
        src_q[wrptr_q] <= rec_source_i;
        tgt_q[wrptr_q] <= rec_target_i;
        typ_q[wrptr_q] <= rec_type_i;
      end
      if (csr_valid && csr_we_i) begin
        case (csr_sel_i)
          2'd0:    src_q[csr_phys] <= csr_wdata_i;
          2'd1:    tgt_q[csr_phys] <= csr_wdata_i;
          2'd2:    typ_q[csr_phys] <= csr_wdata_i[TYPE_W-1:0];
          default: ;
        endcase
      end
    end
  end

  assign csr_rvalid_o = csr_rvalid_q;
  assign csr_rdata_o  = csr_rdata_q;
  assign wrptr_o      = wrptr_q;
  assign frozen_o     = frozen_q;
  assign busy_o       = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_ctr_buffer_ctrl.sv
// Self-checking bench for ctr_buffer_ctrl: directed scenarios plus random traffic
// compared every cycle against a behavioural ring-buffer model.
module tb_ctr_buffer_ctrl;
  localparam int DEPTH  = 16;
  localparam int XLEN   = 64;
  localparam int TYPE_W = 4;
  localparam int PW     = $clog2(DEPTH);

  logic                    clk_i = 1'b0;
  logic                    rst_i;
  logic                    rec_valid_i;
  logic [XLEN-1:0]         rec_source_i;
  logic [XLEN-1:0]         rec_target_i;
  logic [TYPE_W-1:0]       rec_type_i;
  logic [1:0]              rec_priv_i;
  logic [2:0]              priv_en_i;
  logic [(2**TYPE_W)-1:0]  type_inh_i;
  logic                    freeze_i;
  logic                    unfreeze_i;
  logic                    clear_i;
  logic                    csr_req_i;
  logic                    csr_we_i;
  logic [7:0]              csr_idx_i;
  logic [1:0]              csr_sel_i;
  logic [XLEN-1:0]         csr_wdata_i;
  logic                    csr_rvalid_o;
  logic [XLEN-1:0]         csr_rdata_o;
  logic [PW-1:0]           wrptr_o;
  logic                    frozen_o;
  logic                    busy_o;

  ctr_buffer_ctrl #(.DEPTH(DEPTH), .XLEN(XLEN), .TYPE_W(TYPE_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .rec_valid_i(rec_valid_i), .rec_source_i(rec_source_i), .rec_target_i(rec_target_i),
    .rec_type_i(rec_type_i), .rec_priv_i(rec_priv_i), .priv_en_i(priv_en_i),
    .type_inh_i(type_inh_i), .freeze_i(freeze_i), .unfreeze_i(unfreeze_i),
    .clear_i(clear_i), .csr_req_i(csr_req_i), .csr_we_i(csr_we_i),
    .csr_idx_i(csr_idx_i), .csr_sel_i(csr_sel_i), .csr_wdata_i(csr_wdata_i),
    .csr_rvalid_o(csr_rvalid_o), .csr_rdata_o(csr_rdata_o), .wrptr_o(wrptr_o),
    .frozen_o(frozen_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int failures = 0;

  // Reference model: logical ring contents plus bookkeeping
  logic [XLEN-1:0]   m_src [DEPTH];
  logic [XLEN-1:0]   m_tgt [DEPTH];
  logic [TYPE_W-1:0] m_typ [DEPTH];
  int                m_wrptr;
  int                m_clr_rem;
  int                m_clr_idx;
  bit                m_frozen;
  bit                e_rvalid;
  logic [XLEN-1:0]   e_rdata;

  task automatic check_eq(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit priv_ok(input logic [1:0] p, input logic [2:0] en);
    case (p)
      2'd0:    return en[0];
      2'd1:    return en[1];
      2'd3:    return en[2];
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_src[i] = '0; m_tgt[i] = '0; m_typ[i] = '0;
    end
    m_wrptr = 0; m_clr_rem = 0; m_clr_idx = 0; m_frozen = 0;
    e_rvalid = 0; e_rdata = '0;
  endtask

  task automatic idle_inputs();
    rec_valid_i = 0; rec_source_i = '0; rec_target_i = '0; rec_type_i = '0; rec_priv_i = '0;
    freeze_i = 0; unfreeze_i = 0; clear_i = 0;
    csr_req_i = 0; csr_we_i = 0; csr_idx_i = '0; csr_sel_i = '0; csr_wdata_i = '0;
  endtask

  task automatic check_outputs(input string tag);
    check_eq({tag, "_wrptr"},  XLEN'(wrptr_o),      XLEN'(m_wrptr));
    check_eq({tag, "_frozen"}, XLEN'(frozen_o),     XLEN'(m_frozen));
    check_eq({tag, "_busy"},   XLEN'(busy_o),       XLEN'(m_clr_rem != 0));
    check_eq({tag, "_rvalid"}, XLEN'(csr_rvalid_o), XLEN'(e_rvalid));
    check_eq({tag, "_rdata"},  csr_rdata_o,         e_rdata);
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_i = 1;
    model_reset();
    @(negedge clk_i);
    check_outputs("reset");
    rst_i = 0;
  endtask

  // Advance one clock: predict from current inputs, then compare after the edge.
  task automatic tick(input string tag);
    bit run, acc, ok;
    int phys;
    run = (m_clr_rem == 0);
    acc = rec_valid_i && run && !m_frozen && priv_ok(rec_priv_i, priv_en_i)
          && !type_inh_i[rec_type_i] && (rec_type_i != 0);
    ok  = csr_req_i && (int'(csr_idx_i) < DEPTH) && (csr_sel_i != 2'd3) && run;
    phys = 0;
    if (ok) phys = (m_wrptr + DEPTH - 1 - int'(csr_idx_i)) % DEPTH;
    e_rvalid = csr_req_i;
    e_rdata  = '0;
    if (ok && !csr_we_i) begin
      case (csr_sel_i)
        2'd0:    e_rdata = m_src[phys];
        2'd1:    e_rdata = m_tgt[phys];
        default: e_rdata = XLEN'(m_typ[phys]);
      endcase
    end
    if (!run) begin
      m_src[m_clr_idx] = '0; m_tgt[m_clr_idx] = '0; m_typ[m_clr_idx] = '0;
      m_clr_idx++;
      m_clr_rem--;
      if (m_clr_rem == 0) m_wrptr = 0;
    end else if (clear_i) begin
      m_clr_rem = DEPTH;
      m_clr_idx = 0;
    end
    if (acc) begin
      m_src[m_wrptr] = rec_source_i;
      m_tgt[m_wrptr] = rec_target_i;
      m_typ[m_wrptr] = rec_type_i;
      m_wrptr = (m_wrptr + 1) % DEPTH;
    end
    if (ok && csr_we_i) begin
      case (csr_sel_i)
        2'd0:    m_src[phys] = csr_wdata_i;
        2'd1:    m_tgt[phys] = csr_wdata_i;
        default: m_typ[phys] = csr_wdata_i[TYPE_W-1:0];
      endcase
    end
    if (freeze_i)        m_frozen = 1;
    else if (unfreeze_i) m_frozen = 0;
    @(posedge clk_i);
    #1;
    check_outputs(tag);
  endtask

  task automatic set_rec(input logic [1:0] priv, input logic [TYPE_W-1:0] typ);
    rec_valid_i = 1; rec_priv_i = priv; rec_type_i = typ;
    rec_source_i = rnd64(); rec_target_i = rnd64();
  endtask

  task automatic set_read(input int idx, input int sel);
    csr_req_i = 1; csr_we_i = 0; csr_idx_i = 8'(idx); csr_sel_i = 2'(sel); csr_wdata_i = '0;
  endtask

  logic [XLEN-1:0] saved;
  int busy_cycles;

  initial begin
    rst_i = 1;
    priv_en_i = 3'b111; type_inh_i = '0;
    idle_inputs();
    model_reset();
    #12;
    do_reset();

    // 1: three S-mode type-4 records, newest source readable at idx 0
    for (int i = 0; i < 3; i++) begin
      set_rec(2'd1, 4'd4); saved = rec_source_i; tick("t1_rec");
    end
    idle_inputs(); set_read(0, 0); tick("t1_rd");
    check_eq("t1_wrptr3", XLEN'(wrptr_o), XLEN'(3));
    check_eq("t1_newest_src", csr_rdata_o, saved);
    idle_inputs(); tick("t1_idle");

    // 2: DEPTH+2 records wrap; idx DEPTH-1 is the third record pushed
    do_reset();
    for (int i = 0; i < DEPTH + 2; i++) begin
      set_rec(2'd3, 4'(1 + i % 15));
      if (i == 2) saved = rec_source_i;
      tick("t2_rec");
    end
    idle_inputs(); set_read(DEPTH - 1, 0); tick("t2_rd");
    check_eq("t2_wrptr2", XLEN'(wrptr_o), XLEN'(2));
    check_eq("t2_oldest_src", csr_rdata_o, saved);

    // 3: privilege and type filtering
    do_reset();
    priv_en_i = 3'b010;
    set_rec(2'd0, 4'd4); tick("t3_u");
    set_rec(2'd3, 4'd4); tick("t3_m");
    set_rec(2'd2, 4'd4); tick("t3_rsvd");
    type_inh_i = 16'h0010;
    set_rec(2'd1, 4'd4); tick("t3_inh");
    type_inh_i = '0;
    set_rec(2'd1, 4'd0); tick("t3_none");
    check_eq("t3_wrptr0", XLEN'(wrptr_o), XLEN'(0));
    priv_en_i = 3'b111;

    // 4: freeze with a same-cycle record, then drop, then resume
    do_reset();
    set_rec(2'd1, 4'd4); freeze_i = 1; tick("t4_frz");
    check_eq("t4_frz_wrptr", XLEN'(wrptr_o), XLEN'(1));
    check_eq("t4_frozen", XLEN'(frozen_o), XLEN'(1));
    freeze_i = 0; set_rec(2'd1, 4'd4); tick("t4_drop");
    check_eq("t4_drop_wrptr", XLEN'(wrptr_o), XLEN'(1));
    idle_inputs(); unfreeze_i = 1; tick("t4_unfrz");
    unfreeze_i = 0; set_rec(2'd1, 4'd4); tick("t4_resume");
    check_eq("t4_resume_wrptr", XLEN'(wrptr_o), XLEN'(2));

    // 5: clear with 5 entries
    do_reset();
    for (int i = 0; i < 5; i++) begin set_rec(2'd1, 4'd5); tick("t5_rec"); end
    idle_inputs(); clear_i = 1; tick("t5_clr");
    clear_i = 0;
    busy_cycles = 0;
    for (int i = 0; i < DEPTH + 4; i++) begin
      if (busy_o) busy_cycles++;
      if (i == 3) set_read(1, 0); else idle_inputs();
      if (i == 5) clear_i = 1;
      tick("t5_run");
      if (i == 3) check_eq("t5_midclear_rd", csr_rdata_o, '0);
    end
    check_eq("t5_busy_len", XLEN'(busy_cycles), XLEN'(DEPTH));
    check_eq("t5_wrptr0", XLEN'(wrptr_o), XLEN'(0));
    for (int i = 0; i < DEPTH; i++) begin
      set_read(i, i % 3); tick("t5_post");
      check_eq("t5_post_zero", csr_rdata_o, '0);
    end
    idle_inputs();

    // 6: CSR write to idx DEPTH-1 collides with a record on the same slot
    do_reset();
    for (int i = 0; i < 3; i++) begin set_rec(2'd1, 4'd6); tick("t6_rec"); end
    set_rec(2'd1, 4'd7); saved = rec_source_i;
    csr_req_i = 1; csr_we_i = 1; csr_idx_i = 8'(DEPTH - 1); csr_sel_i = 2'd1; csr_wdata_i = 64'hDEAD;
    tick("t6_coll");
    check_eq("t6_wrptr4", XLEN'(wrptr_o), XLEN'(4));
    check_eq("t6_wr_rdata", csr_rdata_o, '0);
    idle_inputs(); set_read(0, 1); tick("t6_rd_tgt");
    check_eq("t6_tgt_dead", csr_rdata_o, 64'hDEAD);
    set_read(0, 0); tick("t6_rd_src");
    check_eq("t6_src_rec", csr_rdata_o, saved);
    set_read(0, 2); tick("t6_rd_typ");
    check_eq("t6_typ_rec", csr_rdata_o, 64'd7);

    // Reset in the middle of a clear
    idle_inputs();
    for (int i = 0; i < 6; i++) begin set_rec(2'd3, 4'd2); tick("tr_rec"); end
    idle_inputs(); clear_i = 1; tick("tr_clr");
    clear_i = 0; tick("tr_mid"); tick("tr_mid");
    do_reset();
    tick("tr_after");
    for (int i = 0; i < 8; i++) begin
      set_read(i, 0); tick("tr_rd");
    end

    // Random traffic
    idle_inputs();
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 49) == 0) priv_en_i = 3'($urandom);
      if ($urandom_range(0, 49) == 0) type_inh_i = 16'($urandom & $urandom & $urandom);
      rec_valid_i  = 1'($urandom);
      rec_priv_i   = 2'($urandom);
      rec_type_i   = TYPE_W'($urandom);
      rec_source_i = rnd64();
      rec_target_i = rnd64();
      freeze_i     = ($urandom_range(0, 29) == 0);
      unfreeze_i   = ($urandom_range(0, 7) == 0);
      clear_i      = ($urandom_range(0, 79) == 0);
      csr_req_i    = 1'($urandom);
      csr_we_i     = ($urandom_range(0, 2) == 0);
      csr_idx_i    = 8'($urandom_range(0, DEPTH + 4));
      csr_sel_i    = 2'($urandom);
      csr_wdata_i  = rnd64();
      tick("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
